// File: rtl/dma_read_engine.sv
// Single-outstanding AXI read engine: fetches transfer_size 32-bit words starting at
// src_addr and pushes each returned beat into a downstream FIFO.
module dma_read_engine #(
    parameter logic [31:0] ADDR_INC = 32'd4
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        start,
    input  logic [31:0] src_addr,
    input  logic [31:0] transfer_size,
    output logic        busy,
    output logic        done,
    output logic [31:0] beats_done,
    output logic [31:0] m_axi_araddr,
    output logic        m_axi_arvalid,
    input  logic        m_axi_arready,
    input  logic [31:0] m_axi_rdata,
    input  logic        m_axi_rvalid,
    output logic        m_axi_rready,
    output logic [31:0] fifo_wdata,
    output logic        fifo_wen,
    input  logic        fifo_full
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_CHECK,
        S_ADDR,
        S_DATA,
        S_DONE
    } state_t;

    state_t      state_q, state_d;
    logic [31:0] addr_q, addr_d;
    logic [31:0] remaining_q, remaining_d;
    logic        busy_q, busy_d;
    logic        done_q, done_d;
    logic [31:0] beats_q, beats_d;
    logic [31:0] araddr_q, araddr_d;
    logic        arvalid_q, arvalid_d;
    logic        rready_q, rready_d;
    logic [31:0] wdata_q, wdata_d;
    logic        wen_q, wen_d;

    always_comb begin
        state_d     = state_q;
        addr_d      = addr_q;
        remaining_d = remaining_q;
        busy_d      = busy_q;
        done_d      = 1'b0;
        beats_d     = beats_q;
        araddr_d    = araddr_q;
        arvalid_d   = arvalid_q;
        rready_d    = rready_q;
        wdata_d     = wdata_q;
        wen_d       = 1'b0;

        case (state_q)
            S_IDLE: begin
                if (start) begin
                    beats_d = 32'd0;
                    if (transfer_size != 32'd0) begin
                        addr_d      = src_addr;
                        remaining_d = transfer_size;
                        busy_d      = 1'b1;
                        state_d     = S_CHECK;
                    end else begin
                        state_d = S_DONE;
                    end
                end
            end
            // Space is only checked here; one outstanding read means one free slot suffices.
            S_CHECK: begin
                if (!fifo_full) begin
                    arvalid_d = 1'b1;
                    araddr_d  = addr_q;
                    state_d   = S_ADDR;
                end
            end
            S_ADDR: begin
                if (arvalid_q && m_axi_arready) begin
                    arvalid_d = 1'b0;
                    rready_d  = 1'b1;
                    state_d   = S_DATA;
                end
            end
            S_DATA: begin
                if (m_axi_rvalid && rready_q) begin
                    rready_d    = 1'b0;
                    wen_d       = 1'b1;
                    wdata_d     = m_axi_rdata;
                    beats_d     = beats_q + 32'd1;
                    remaining_d = remaining_q - 32'd1;
                    addr_d      = addr_q + ADDR_INC;
                    if (remaining_q == 32'd1) begin
                        done_d  = 1'b1;
                        busy_d  = 1'b0;
                        state_d = S_DONE;
                    end else begin
                        state_d = S_CHECK;
                    end
                end
            end
            // Entered with done already raised after a last beat; a zero-length request
            // arrives here with done low and spends one extra cycle raising it.
            S_DONE: begin
                if (done_q) begin
                    state_d = S_IDLE;
                end else begin
                    done_d = 1'b1;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= S_IDLE;
            addr_q      <= 32'd0;
            remaining_q <= 32'd0;
            busy_q      <= 1'b0;
            done_q      <= 1'b0;
            beats_q     <= 32'd0;
            araddr_q    <= 32'd0;
            arvalid_q   <= 1'b0;
            rready_q    <= 1'b0;
            wdata_q     <= 32'd0;
            wen_q       <= 1'b0;
        end else begin
            state_q     <= state_d;
            addr_q      <= addr_d;
            remaining_q <= remaining_d;
            busy_q      <= busy_d;
            done_q      <= done_d;
            beats_q     <= beats_d;
            araddr_q    <= araddr_d;
            arvalid_q   <= arvalid_d;
            rready_q    <= rready_d;
            wdata_q     <= wdata_d;
            wen_q       <= wen_d;
        end
    end

    assign busy          = busy_q;
    assign done          = done_q;
    assign beats_done    = beats_q;
    assign m_axi_araddr  = araddr_q;
    assign m_axi_arvalid = arvalid_q;
    assign m_axi_rready  = rready_q;
    assign fifo_wdata    = wdata_q;
    assign fifo_wen      = wen_q;

endmodule

// File: tb/tb_dma_read_engine.sv
// Bench for dma_read_engine: directed corner cases plus randomized traffic, all checked
// every cycle against a transaction-level model of the read engine.
module tb_dma_read_engine;

    localparam logic [31:0] INC = 32'd4;

    logic        clk = 1'b0;
    logic        rst, start;
    logic [31:0] src_addr, transfer_size;
    logic        busy, done;
    logic [31:0] beats_done, m_axi_araddr, m_axi_rdata, fifo_wdata;
    logic        m_axi_arvalid, m_axi_arready, m_axi_rvalid, m_axi_rready;
    logic        fifo_wen, fifo_full;

    always #5 clk = ~clk;

    dma_read_engine #(.ADDR_INC(INC)) dut (
        .clk(clk), .rst(rst), .start(start), .src_addr(src_addr),
        .transfer_size(transfer_size), .busy(busy), .done(done), .beats_done(beats_done),
        .m_axi_araddr(m_axi_araddr), .m_axi_arvalid(m_axi_arvalid),
        .m_axi_arready(m_axi_arready), .m_axi_rdata(m_axi_rdata),
        .m_axi_rvalid(m_axi_rvalid), .m_axi_rready(m_axi_rready),
        .fifo_wdata(fifo_wdata), .fifo_wen(fifo_wen), .fifo_full(fifo_full)
    );

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int n_tests = 0;
    int n_fail  = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h, expected %h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // ---------------- slave / FIFO responder ----------------
    int          resp_mode = 1;
    logic        full_force = 1'b0;
    int          ar_stall_cfg = 0;
    logic [31:0] dir_data [0:7];

    initial begin
        int   stall_cnt;
        int   didx;
        logic arv_last, rr_last;
        stall_cnt = 0; didx = 0; arv_last = 1'b0; rr_last = 1'b0;
        m_axi_arready = 1'b0; m_axi_rvalid = 1'b0; m_axi_rdata = 32'd0; fifo_full = 1'b0;
        forever begin
            @(posedge clk);
            #2;
            if (resp_mode == 0) begin
                m_axi_arready = ($urandom_range(0, 2) == 0);
                m_axi_rvalid  = ($urandom_range(0, 2) == 0);
                m_axi_rdata   = $urandom;
                fifo_full     = ($urandom_range(0, 3) == 0);
            end else begin
                if (start) didx = 0;
                fifo_full = full_force;
                if (m_axi_arvalid && !arv_last) begin
                    stall_cnt     = ar_stall_cfg;
                    m_axi_arready = 1'b0;
                end else if (m_axi_arvalid) begin
                    if (stall_cnt > 0) begin
                        stall_cnt--;
                        m_axi_arready = 1'b0;
                    end else begin
                        m_axi_arready = 1'b1;
                    end
                end else begin
                    m_axi_arready = 1'b0;
                end
                m_axi_rvalid = m_axi_rready && rr_last;
                if (m_axi_rvalid) begin
                    m_axi_rdata = dir_data[didx & 7];
                    didx++;
                end else begin
                    m_axi_rdata = $urandom;
                end
            end
            arv_last = m_axi_arvalid;
            rr_last  = m_axi_rready;
        end
    end

    // ---------------- reference model + per-cycle compare ----------------
    bit          mon_en = 1'b0;
    logic [31:0] ar_log[$];
    logic [31:0] wen_log[$];
    int          done_cnt = 0, done_cyc = 0, arv_rise_cyc = 0, ar_len = 0;

    initial begin
        logic        e_busy, e_done, e_arv, e_rr, e_wen;
        logic [31:0] e_beats, e_addr, e_wdata;
        logic        n_busy, n_done, n_arv, n_rr, n_wen;
        logic [31:0] n_beats, n_addr, n_wdata;
        bit          strict_addr, strict_wdata, m_active, m_check, m_zero, ar_hs, r_hs;
        int unsigned m_rem;
        logic [31:0] m_cur;
        logic        arv_prev;
        e_busy = 0; e_done = 0; e_arv = 0; e_rr = 0; e_wen = 0;
        e_beats = 0; e_addr = 0; e_wdata = 0;
        strict_addr = 1; strict_wdata = 1; m_active = 0; m_check = 0; m_zero = 0;
        m_rem = 0; m_cur = 0; arv_prev = 0;
        forever begin
            @(negedge clk);
            if (mon_en) begin
                chk("busy", 32'(busy), 32'(e_busy));
                chk("done", 32'(done), 32'(e_done));
                chk("beats_done", beats_done, e_beats);
                chk("arvalid", 32'(m_axi_arvalid), 32'(e_arv));
                chk("rready", 32'(m_axi_rready), 32'(e_rr));
                chk("fifo_wen", 32'(fifo_wen), 32'(e_wen));
                if (e_arv || strict_addr) chk("araddr", m_axi_araddr, e_addr);
                if (e_wen || strict_wdata) chk("fifo_wdata", fifo_wdata, e_wdata);
            end
            if (!rst) begin
                if (m_axi_arvalid && !arv_prev) arv_rise_cyc = cyc;
                if (m_axi_arvalid && m_axi_arready) begin
                    ar_log.push_back(m_axi_araddr);
                    ar_len = cyc - arv_rise_cyc;
                end
                if (fifo_wen) wen_log.push_back(fifo_wdata);
                if (done) begin
                    done_cnt++;
                    done_cyc = cyc;
                    $display("[TB] transfer complete at cycle %0d, beats_done=%0d", cyc, beats_done);
                end
            end
            arv_prev = m_axi_arvalid;

            if (rst) begin
                e_busy = 0; e_done = 0; e_arv = 0; e_rr = 0; e_wen = 0;
                e_beats = 0; e_addr = 0; e_wdata = 0;
                strict_addr = 1; strict_wdata = 1;
                m_active = 0; m_check = 0; m_zero = 0; m_rem = 0;
            end else begin
                ar_hs = e_arv && m_axi_arready;
                r_hs  = e_rr && m_axi_rvalid;
                n_busy = e_busy; n_done = 0; n_arv = e_arv; n_rr = e_rr; n_wen = 0;
                n_beats = e_beats; n_addr = e_addr; n_wdata = e_wdata;
                if (m_check && !fifo_full) begin
                    n_arv = 1; n_addr = m_cur; m_check = 0; strict_addr = 0;
                end
                if (ar_hs) begin
                    n_arv = 0; n_rr = 1;
                end
                if (r_hs) begin
                    n_rr = 0; n_wen = 1; n_wdata = m_axi_rdata; strict_wdata = 0;
                    n_beats = e_beats + 1;
                    m_cur = m_cur + INC;
                    m_rem--;
                    if (m_rem == 0) begin
                        n_done = 1; n_busy = 0;
                    end else begin
                        m_check = 1;
                    end
                end
                if (m_zero) begin
                    n_done = 1; m_zero = 0;
                end
                if (start && !m_active) begin
                    m_active = 1; n_beats = 0;
                    if (transfer_size != 0) begin
                        m_cur = src_addr; m_rem = transfer_size; m_check = 1; n_busy = 1;
                    end else begin
                        m_zero = 1;
                    end
                end else if (e_done) begin
                    m_active = 0;
                end
                e_busy = n_busy; e_done = n_done; e_arv = n_arv; e_rr = n_rr; e_wen = n_wen;
                e_beats = n_beats; e_addr = n_addr; e_wdata = n_wdata;
            end
        end
    end

    // ---------------- stimulus ----------------
    int st_cyc = 0;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_start(input logic [31:0] a, input logic [31:0] n);
        start = 1'b1; src_addr = a; transfer_size = n; st_cyc = cyc;
        tick();
        start = 1'b0; src_addr = $urandom; transfer_size = $urandom;
    endtask

    task automatic wait_done(input int base, input int bound);
        int i;
        i = 0;
        while (done_cnt == base && i < bound) begin
            tick();
            i++;
        end
        chk("done_seen", 32'(done_cnt != base), 32'd1);
    endtask

    initial begin
        #900000;
        $display("FAIL watchdog: got no completion, expected end of test");
        $fatal(1, "timeout");
    end

    initial begin
        int ab, wb, db, f, i;
        logic [31:0] a, n;
        rst = 1'b1; start = 1'b0; src_addr = 32'd0; transfer_size = 32'd0;
        dir_data[0] = 32'hA0A0_0001; dir_data[1] = 32'hB0B0_0002; dir_data[2] = 32'hC0C0_0003;
        for (int k = 3; k < 8; k++) dir_data[k] = 32'h1111_0000 + k;
        tick(); tick();
        mon_en = 1'b1;
        chk("rst_busy", 32'(busy), 32'd0);
        chk("rst_arvalid", 32'(m_axi_arvalid), 32'd0);
        chk("rst_araddr", m_axi_araddr, 32'd0);
        chk("rst_beats", beats_done, 32'd0);
        rst = 1'b0;
        tick();

        // three-beat transfer with prompt slave
        ab = ar_log.size(); wb = wen_log.size(); db = done_cnt;
        do_start(32'h0000_1000, 32'd3);
        wait_done(db, 200); tick();
        chk("basic_ar0", ar_log[ab], 32'h0000_1000);
        chk("basic_ar1", ar_log[ab+1], 32'h0000_1004);
        chk("basic_ar2", ar_log[ab+2], 32'h0000_1008);
        chk("basic_nwen", 32'(wen_log.size() - wb), 32'd3);
        chk("basic_w0", wen_log[wb], 32'hA0A0_0001);
        chk("basic_w1", wen_log[wb+1], 32'hB0B0_0002);
        chk("basic_w2", wen_log[wb+2], 32'hC0C0_0003);
        chk("basic_ndone", 32'(done_cnt - db), 32'd1);
        chk("basic_beats", beats_done, 32'd3);
        repeat (2) tick();

        // zero-length request
        ab = ar_log.size(); db = done_cnt;
        do_start(32'h0000_2000, 32'd0);
        wait_done(db, 20); tick();
        chk("zero_latency", 32'(done_cyc - st_cyc), 32'd2);
        chk("zero_nar", 32'(ar_log.size() - ab), 32'd0);
        chk("zero_beats", beats_done, 32'd0);
        repeat (2) tick();

        // FIFO full holds the engine before the address phase
        db = done_cnt; full_force = 1'b1;
        do_start(32'h0000_3000, 32'd1);
        repeat (4) tick();
        chk("full_arvalid_low", 32'(m_axi_arvalid), 32'd0);
        full_force = 1'b0; f = cyc;
        wait_done(db, 50); tick();
        chk("full_rise", 32'(arv_rise_cyc - f), 32'd1);
        repeat (2) tick();

        // stalled arready and an ignored second start
        ab = ar_log.size(); db = done_cnt; ar_stall_cfg = 4;
        do_start(32'h0000_4000, 32'd1);
        tick();
        do_start(32'h0000_5000, 32'd3);
        wait_done(db, 100); tick();
        ar_stall_cfg = 0;
        chk("stall_addr", ar_log[ab], 32'h0000_4000);
        chk("stall_nar", 32'(ar_log.size() - ab), 32'd1);
        chk("stall_len", 32'(ar_len), 32'd5);
        chk("stall_beats", beats_done, 32'd1);
        repeat (2) tick();

        // address wrap
        ab = ar_log.size(); db = done_cnt;
        do_start(32'hFFFF_FFFC, 32'd2);
        wait_done(db, 100); tick();
        chk("wrap_ar0", ar_log[ab], 32'hFFFF_FFFC);
        chk("wrap_ar1", ar_log[ab+1], 32'h0000_0000);
        repeat (2) tick();

        // reset during the data phase of beat 2 of 4, together with a start
        wb = wen_log.size(); db = done_cnt;
        do_start(32'h0000_6000, 32'd4);
        i = 0;
        while (!((wen_log.size() - wb) >= 1 && m_axi_rready) && i < 200) begin
            tick();
            i++;
        end
        chk("reached_beat2", 32'(i < 200), 32'd1);
        rst = 1'b1; start = 1'b1; transfer_size = 32'd2; src_addr = 32'h0000_9000;
        tick();
        rst = 1'b0; start = 1'b0;
        chk("mid_rst_busy", 32'(busy), 32'd0);
        chk("mid_rst_done", 32'(done), 32'd0);
        chk("mid_rst_beats", beats_done, 32'd0);
        chk("mid_rst_araddr", m_axi_araddr, 32'd0);
        chk("mid_rst_arvalid", 32'(m_axi_arvalid), 32'd0);
        chk("mid_rst_rready", 32'(m_axi_rready), 32'd0);
        chk("mid_rst_wdata", fifo_wdata, 32'd0);
        chk("mid_rst_wen", 32'(fifo_wen), 32'd0);
        repeat (10) tick();
        chk("mid_rst_nodone", 32'(done_cnt - db), 32'd0);
        db = done_cnt;
        do_start(32'h0000_7000, 32'd1);
        wait_done(db, 50); tick();
        chk("post_rst_beats", beats_done, 32'd1);
        repeat (2) tick();

        // randomized traffic
        resp_mode = 0;
        for (int it = 0; it < 60; it++) begin
            a = ($urandom_range(0, 4) == 0) ? (32'hFFFF_FFF0 | ($urandom & 32'hC))
                                             : ($urandom & 32'hFFFF_FFFC);
            n = 32'($urandom_range(0, 6));
            db = done_cnt;
            do_start(a, n);
            if ($urandom_range(0, 3) == 0) begin
                repeat ($urandom_range(0, 3)) tick();
                do_start($urandom, 32'($urandom_range(1, 9)));
            end
            if ($urandom_range(0, 9) == 0) begin
                repeat ($urandom_range(1, 6)) tick();
                rst = 1'b1;
                tick();
                rst = 1'b0;
            end else begin
                wait_done(db, 2000);
            end
            i = 0;
            while ((busy || done) && i < 2000) begin
                tick();
                i++;
            end
            repeat (3) tick();
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
